// File: rtl/traffic_request_conditioner.sv
// Front end for trafficController: synchronises and debounces the raw button/switch inputs,
// latches pedestrian requests until served and turns emergency requests into spaced pulses.
module traffic_request_conditioner #(
    parameter int DEBOUNCE   = 3,
    parameter int EMERG_HOLD = 2,
    parameter int COOLDOWN   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_T1ped,
    input  logic raw_T2ped,
    input  logic raw_eLeft,
    input  logic raw_eRight,
    input  logic T1Walk,
    input  logic T2Walk,
    output logic T1pedButton,
    output logic T2pedButton,
    output logic Emergency_Left,
    output logic Emergency_Right,
    output logic emerg_busy
);

    localparam int DBW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TMAX      = (EMERG_HOLD > COOLDOWN) ? EMERG_HOLD : COOLDOWN;
    localparam int TW        = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int HOLD_LAST = EMERG_HOLD - 1;
    localparam int COOL_LAST = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

    // Lane order: 0 = T1 ped, 1 = T2 ped, 2 = emergency left, 3 = emergency right.
    logic [3:0] raw_in;
    logic [3:0] rise;
    logic [1:0] walk;

    assign raw_in = {raw_eRight, raw_eLeft, raw_T2ped, raw_T1ped};
    assign walk   = {T2Walk, T1Walk};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_in
            logic           sync1_q, sync1_d;
            logic           sync2_q, sync2_d;
            logic           db_q, db_d;
            logic [DBW-1:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d = raw_in[gi];
                sync2_d = sync1_q;
                db_d    = db_q;
                cnt_d   = '0;
                if (sync2_q != db_q) begin
                    if (cnt_q == DBW'(DEBOUNCE - 1)) begin
                        db_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + DBW'(1);
                    end
                end
            end

            assign rise[gi] = db_d & ~db_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    db_q    <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                end
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_ped
            logic ped_pend_q, ped_pend_d;

            // A press seen while the side is already walking is dropped, not queued.
            always_comb begin
                ped_pend_d = walk[gi] ? 1'b0 : (ped_pend_q | rise[gi]);
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ped_pend_q <= 1'b0;
                end else begin
                    ped_pend_q <= ped_pend_d;
                end
            end
        end
    endgenerate

    assign T1pedButton = g_ped[0].ped_pend_q;
    assign T2pedButton = g_ped[1].ped_pend_q;

    typedef enum logic [1:0] {IDLE, E_LEFT, E_RIGHT, COOL} emerg_state_t;

    emerg_state_t   state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           pend_l_q, pend_l_d;
    logic           pend_r_q, pend_r_d;
    logic           dispatch;
    logic           em_left_q, em_right_q, busy_q;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        pend_l_d = pend_l_q | rise[2];
        pend_r_d = pend_r_q | rise[3];
        dispatch = 1'b0;
        case (state_q)
            IDLE: dispatch = 1'b1;
            E_LEFT, E_RIGHT: begin
                if (tmr_q == TW'(HOLD_LAST)) begin
                    tmr_d   = '0;
                    state_d = (COOLDOWN == 0) ? IDLE : COOL;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            COOL: begin
                // The last cooldown cycle is also the IDLE-exit edge, so a waiting
                // request starts here rather than one cycle later.
                if (tmr_q == TW'(COOL_LAST)) begin
                    tmr_d    = '0;
                    state_d  = IDLE;
                    dispatch = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (dispatch) begin
            if (pend_l_q) begin
                state_d  = E_LEFT;
                pend_l_d = rise[2];
            end else if (pend_r_q) begin
                state_d  = E_RIGHT;
                pend_r_d = rise[3];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            pend_l_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            em_left_q  <= 1'b0;
            em_right_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            em_left_q  <= (state_d == E_LEFT);
            em_right_q <= (state_d == E_RIGHT);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign Emergency_Left  = em_left_q;
    assign Emergency_Right = em_right_q;
    assign emerg_busy      = busy_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Bench for traffic_request_conditioner: directed scenarios plus random traffic,
// all compared each cycle against an event-level model of the request rules.
module tb_traffic_request_conditioner;

    localparam int DEBOUNCE   = 3;
    localparam int EMERG_HOLD = 2;
    localparam int COOLDOWN   = 4;

    logic clk = 1'b0;
    logic reset;
    logic raw_T1ped, raw_T2ped, raw_eLeft, raw_eRight;
    logic T1Walk, T2Walk;
    logic T1pedButton, T2pedButton, Emergency_Left, Emergency_Right, emerg_busy;

    always #5 clk = ~clk;

    traffic_request_conditioner #(
        .DEBOUNCE  (DEBOUNCE),
        .EMERG_HOLD(EMERG_HOLD),
        .COOLDOWN  (COOLDOWN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .raw_T1ped      (raw_T1ped),
        .raw_T2ped      (raw_T2ped),
        .raw_eLeft      (raw_eLeft),
        .raw_eRight     (raw_eRight),
        .T1Walk         (T1Walk),
        .T2Walk         (T2Walk),
        .T1pedButton    (T1pedButton),
        .T2pedButton    (T2pedButton),
        .Emergency_Left (Emergency_Left),
        .Emergency_Right(Emergency_Right),
        .emerg_busy     (emerg_busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: inputs reach the debouncer two edges late; a level is accepted
    // after DEBOUNCE consecutive differing samples; pulses are scheduled by start edge.
    bit     m_s1[4], m_s2[4], m_db[4];
    int     m_run[4];
    bit     m_ped[2], m_pe[2];
    int     m_dir;
    longint m_n, m_start;

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
        end
        for (int j = 0; j < 2; j++) begin
            m_ped[j] = 0; m_pe[j] = 0;
        end
        m_dir   = -1;
        m_start = -1000;
    endfunction

    function automatic bit exp_left();
        return (m_dir == 0) && ((m_n - m_start) < EMERG_HOLD);
    endfunction

    function automatic bit exp_right();
        return (m_dir == 1) && ((m_n - m_start) < EMERG_HOLD);
    endfunction

    function automatic bit exp_busy();
        return (m_dir >= 0) && ((m_n - m_start) < EMERG_HOLD + COOLDOWN);
    endfunction

    task automatic model_edge();
        bit raw[4];
        bit wk[2];
        bit rs[4];
        bit free;
        int acc;
        int gap;
        raw[0] = raw_T1ped; raw[1] = raw_T2ped; raw[2] = raw_eLeft; raw[3] = raw_eRight;
        wk[0] = T1Walk; wk[1] = T2Walk;
        if (reset !== 1'b1) begin
            m_clear();
            return;
        end
        m_n++;
        for (int i = 0; i < 4; i++) begin
            rs[i] = 0;
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEBOUNCE) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                    rs[i]    = m_s2[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        for (int j = 0; j < 2; j++)
            m_ped[j] = wk[j] ? 1'b0 : (m_ped[j] | rs[j]);
        gap  = EMERG_HOLD + ((COOLDOWN == 0) ? 1 : COOLDOWN);
        free = (m_n >= m_start + gap);
        acc  = -1;
        if (free) begin
            if (m_pe[0]) acc = 0;
            else if (m_pe[1]) acc = 1;
            if (acc >= 0) begin
                m_dir   = acc;
                m_start = m_n;
            end
        end
        for (int k = 0; k < 2; k++)
            m_pe[k] = (m_pe[k] && (acc != k)) || rs[2 + k];
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_T1ped"}, T1pedButton, m_ped[0]);
        chk({tag, "_T2ped"}, T2pedButton, m_ped[1]);
        chk({tag, "_eL"}, Emergency_Left, exp_left());
        chk({tag, "_eR"}, Emergency_Right, exp_right());
        chk({tag, "_busy"}, emerg_busy, exp_busy());
        chk({tag, "_excl"}, Emergency_Left & Emergency_Right, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic do_async_reset();
        reset = 1'b0;
        #1;
        m_clear();
        chk("rst_T1", T1pedButton, 1'b0);
        chk("rst_T2", T2pedButton, 1'b0);
        chk("rst_eL", Emergency_Left, 1'b0);
        chk("rst_eR", Emergency_Right, 1'b0);
        chk("rst_busy", emerg_busy, 1'b0);
    endtask

    task automatic set_raw(input int k, input logic v);
        case (k)
            0: raw_T1ped  = v;
            1: raw_T2ped  = v;
            2: raw_eLeft  = v;
            default: raw_eRight = v;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  bounce[10];
        int  hold[4];
        int  whold[2];
        int  rcount;
        bit  prev_r;
        bit  seen;

        raw_T1ped = 0; raw_T2ped = 0; raw_eLeft = 0; raw_eRight = 0;
        T1Walk = 0; T2Walk = 0;
        m_n = 0;
        m_clear();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;

        // Clean T1 press: button rises on edge 5, cleared by walk
        raw_T1ped = 1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 4) chk("t1_press_e4", T1pedButton, 1'b0);
            if (e == 5) chk("t1_press_e5", T1pedButton, 1'b1);
        end
        raw_T1ped = 0;
        repeat (4) step();
        chk("t1_held", T1pedButton, 1'b1);
        T1Walk = 1;
        step();
        chk("t1_served", T1pedButton, 1'b0);
        chk("t2_quiet", T2pedButton, 1'b0);
        T1Walk = 0;
        repeat (6) step();

        // Bounce rejection on T2, then a clean 4-cycle hold
        bounce = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 1};
        for (int i = 0; i < 10; i++) begin
            raw_T2ped = bounce[i];
            step();
        end
        raw_T2ped = 0;
        repeat (3) step();
        chk("t2_bounce", T2pedButton, 1'b0);
        raw_T2ped = 1;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 4) begin
                chk("t2_hold_e4", T2pedButton, 1'b0);
                raw_T2ped = 0;
            end
            if (e == 5) chk("t2_hold_e5", T2pedButton, 1'b1);
        end
        T2Walk = 1;
        step();
        T2Walk = 0;
        repeat (6) step();

        // Press while T1 is walking is discarded; a later press latches
        T1Walk = 1;
        raw_T1ped = 1;
        repeat (6) step();
        raw_T1ped = 0;
        repeat (6) step();
        chk("t1_walk_drop", T1pedButton, 1'b0);
        T1Walk = 0;
        step();
        raw_T1ped = 1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) chk("t1_repress", T1pedButton, 1'b1);
        end
        raw_T1ped = 0;
        T1Walk = 1;
        step();
        T1Walk = 0;
        repeat (6) step();

        // Simultaneous emergencies: left on edges 6-7, right on edges 12-13
        raw_eLeft = 1; raw_eRight = 1;
        for (int e = 1; e <= 18; e++) begin
            step();
            if (e == 4) begin
                raw_eLeft = 0; raw_eRight = 0;
            end
            chk($sformatf("sim_L_e%0d", e), Emergency_Left, (e == 6 || e == 7));
            chk($sformatf("sim_R_e%0d", e), Emergency_Right, (e == 12 || e == 13));
        end
        repeat (6) step();

        // Right request lands during cooldown; a re-press during its pulse gives one more
        raw_eLeft = 1;
        rcount = 0;
        prev_r = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (Emergency_Right && !prev_r) rcount++;
            prev_r = Emergency_Right;
            if (e == 11) chk("cool_R_e11", Emergency_Right, 1'b0);
            if (e == 12) chk("cool_R_e12", Emergency_Right, 1'b1);
            if (e == 4)  raw_eLeft = 0;
            if (e == 3)  raw_eRight = 1;
            if (e == 7)  raw_eRight = 0;
            if (e == 11) raw_eRight = 1;
            if (e == 15) raw_eRight = 0;
        end
        chk_int("cool_R_pulses", rcount, 2);

        // Reset in the middle of a left pulse
        raw_eLeft = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = Emergency_Left;
        end
        chk("mid_wait_eL", seen, 1'b1);
        raw_eLeft = 0;
        do_async_reset();
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst_eL", Emergency_Left, 1'b0);
            chk("post_rst_eR", Emergency_Right, 1'b0);
        end

        // Random traffic against the model
        for (int k = 0; k < 4; k++) hold[k] = 0;
        for (int j = 0; j < 2; j++) whold[j] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (hold[k] == 0) begin
                    set_raw(k, 1'($urandom_range(0, 1)));
                    hold[k] = $urandom_range(1, 7);
                end else begin
                    hold[k]--;
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (whold[j] == 0) begin
                    if (j == 0) T1Walk = ($urandom_range(0, 5) == 0);
                    else        T2Walk = ($urandom_range(0, 5) == 0);
                    whold[j] = $urandom_range(1, 4);
                end else begin
                    whold[j]--;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                do_async_reset();
                repeat ($urandom_range(1, 2)) step();
                reset = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
